// File: rtl/cpu_cpu_cpu_div_cell.sv
// Iterative radix-2 restoring divider, signed or unsigned, DATA_W cycles per
// divide plus one sign-fix cycle and one result cycle. The datapath works on
// operand magnitudes; sign correction is applied once, in FIX.
module cpu_cpu_cpu_div_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_signed,
    input  logic              E_start,
    input  logic              E_abort,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quot,
    output logic [DATA_W-1:0] M_div_rem,
    output logic              M_div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  iter_cnt;
    logic              accept;

    // Magnitude datapath: rem_acc always stays below the divisor, so the
    // shifted partial remainder needs exactly one extra bit.
    logic [DATA_W-1:0] rem_acc;
    logic [DATA_W-1:0] quot_sr;
    logic [DATA_W-1:0] divisor_mag;
    logic              neg_quot;
    logic              neg_rem;
    logic              by_zero;

    logic [DATA_W-1:0] src1_mag;
    logic [DATA_W-1:0] src2_mag;
    logic [DATA_W:0]   part_rem;
    logic [DATA_W:0]   trial_diff;
    logic              fits;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    assign accept = (state == IDLE) && E_start && !E_abort;

    // Operand magnitudes; the most-negative value maps onto itself, which
    // reads correctly as an unsigned magnitude of 2^(DATA_W-1).
    assign src1_mag = (E_signed && E_src1[DATA_W-1]) ? -E_src1 : E_src1;
    assign src2_mag = (E_signed && E_src2[DATA_W-1]) ? -E_src2 : E_src2;

    // One shift/subtract step: the borrow out of the extended subtraction
    // tells whether the divisor fits into the shifted partial remainder.
    assign part_rem   = {rem_acc, quot_sr[DATA_W-1]};
    assign trial_diff = part_rem - {1'b0, divisor_mag};
    assign fits       = ~trial_diff[DATA_W];

    // Sign correction; a zero divisor overrides the quotient with all-ones,
    // while the remainder path naturally reconstructs the dividend.
    assign quot_fix = by_zero  ? '1 : (neg_quot ? -quot_sr : quot_sr);
    assign rem_fix  = neg_rem  ? -rem_acc : rem_acc;

    // State register, synchronous reset has priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge regardless of block order.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; abort wins over start in IDLE and over progress elsewhere.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (E_abort)                    state_nxt = IDLE;
                else if (iter_cnt == LAST_ITER) state_nxt = FIX;
            end
            FIX:  state_nxt = E_abort ? IDLE : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        M_div_busy = (state != IDLE);
        M_div_done = (state == DONE);
    end

    // Iteration counter: runs 0..DATA_W-1 while staying in CALC, else parked at 0.
    always_ff @(posedge clk) begin
        if (reset)
            iter_cnt <= '0;
        else if (state == CALC && state_nxt == CALC)
            iter_cnt <= iter_cnt + 1'b1;
        else
            iter_cnt <= '0;
    end

    // Operand capture on acceptance and one radix-2 step per CALC cycle.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are deliberately not reset; they are always
        // loaded at acceptance before anything reads them.
        if (accept) begin
            rem_acc     <= '0;
            quot_sr     <= src1_mag;
            divisor_mag <= src2_mag;
            neg_quot    <= E_signed && (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
            neg_rem     <= E_signed && E_src1[DATA_W-1];
            by_zero     <= (E_src2 == '0);
        end else if (state == CALC) begin
            rem_acc <= fits ? trial_diff[DATA_W-1:0] : part_rem[DATA_W-1:0];
            quot_sr <= {quot_sr[DATA_W-2:0], fits};
        end
    end

    // Result registers: load only on the FIX->DONE edge, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            M_div_quot    <= '0;
            M_div_rem     <= '0;
            M_div_by_zero <= 1'b0;
        end else if (state == FIX && state_nxt == DONE) begin
            M_div_quot    <= quot_fix;
            M_div_rem     <= rem_fix;
            M_div_by_zero <= by_zero;
        end
    end

endmodule

// File: tb/tb_cpu_cpu_cpu_div_cell.sv
// Self-checking bench: table of directed divides, a few random ones against a
// behavioural model, and hand-written abort / reset / ignored-start sequences.
module tb_cpu_cpu_cpu_div_cell;

    localparam int W       = 32;
    localparam int LATENCY = W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] E_src1, E_src2;
    logic         E_signed, E_start, E_abort;
    logic         M_div_busy, M_div_done, M_div_by_zero;
    logic [W-1:0] M_div_quot, M_div_rem;

    cpu_cpu_cpu_div_cell #(.DATA_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .E_src1       (E_src1),
        .E_src2       (E_src2),
        .E_signed     (E_signed),
        .E_start      (E_start),
        .E_abort      (E_abort),
        .M_div_busy   (M_div_busy),
        .M_div_done   (M_div_done),
        .M_div_quot   (M_div_quot),
        .M_div_rem    (M_div_rem),
        .M_div_by_zero(M_div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           accept_edge;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   busy_run  = 0;
    int   done_seen = 0;
    int   accepted  = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e.accept_edge = 0;
        e.z = 1'b0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.z = 1'b1;
        end else if (s) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                e.q = a; e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b; e.r = a % b;
        end
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (M_div_busy) busy_run++;
        else            busy_run = 0;
        if (M_div_done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quot",    M_div_quot, e.q);
                check("rem",     M_div_rem,  e.r);
                check("by_zero", {31'd0, M_div_by_zero}, {31'd0, e.z});
                check("latency", cyc + 1 - e.accept_edge, LATENCY);
                check("busy_cycles", busy_run, LATENCY);
            end
        end
    end

    // Drive one start pulse for a cycle; optionally record the expectation.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input bit push, input exp_t e);
        @(negedge clk);
        E_src1 = a; E_src2 = b; E_signed = s; E_start = 1'b1;
        if (push) begin
            e.accept_edge = cyc + 1;
            exp_q.push_back(e);
            accepted++;
        end
        @(negedge clk);
        E_start = 1'b0;
        E_src1  = $urandom; E_src2 = $urandom; E_signed = $urandom_range(1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3 * LATENCY) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        start_op(a, b, s, 1'b1, e);
        wait_drain();
    endtask

    vec_t vecs[12];
    exp_t e;
    logic [W-1:0] last_q, last_r;
    logic         last_z;

    initial begin
        vecs[0]  = '{32'd100,      32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2]  = '{32'd7,        32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
        vecs[4]  = '{32'h12345678, 32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1'b1};
        vecs[5]  = '{32'hFFFFFFF9, 32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF,   1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[7]  = '{32'd5,        32'd10,         1'b0, 32'd0,          32'd5,          1'b0};
        vecs[8]  = '{32'hFFFFFFF9, 32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
        vecs[9]  = '{32'h80000000, 32'd2,          1'b0, 32'h40000000,   32'd0,          1'b0};
        vecs[10] = '{32'h80000000, 32'd7,          1'b1, 32'hEDB6DB6E,   32'hFFFFFFFE,   1'b0};
        vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0};

        reset = 1'b1; E_start = 1'b0; E_abort = 1'b0;
        E_src1 = '0; E_src2 = '0; E_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, M_div_busy},    32'd0);
        check("rst_done",  {31'd0, M_div_done},    32'd0);
        check("rst_quot",  M_div_quot,             32'd0);
        check("rst_rem",   M_div_rem,              32'd0);
        check("rst_bz",    {31'd0, M_div_by_zero}, 32'd0);
        reset = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            e = '{vecs[i].q, vecs[i].r, vecs[i].z, 0};
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, e);
        end

        // Random operands against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            logic s;
            a = $urandom; b = (i == 3) ? 32'd0 : $urandom >> $urandom_range(31);
            s = i[0];
            run_op(a, b, s, ref_div(a, b, s));
        end

        last_q = 32'd1; last_r = 32'd0; last_z = 1'b0;
        run_op(32'd9, 32'd9, 1'b0, '{32'd1, 32'd0, 1'b0, 0});

        // Abort in CALC cycle 10: no done, results hold, immediate restart works.
        start_op(32'd1000, 32'd3, 1'b0, 1'b0, e);
        repeat (9) @(negedge clk);
        E_abort = 1'b1;
        @(negedge clk);
        E_abort = 1'b0;
        check("abort_busy", {31'd0, M_div_busy}, 32'd0);
        check("abort_quot", M_div_quot, last_q);
        check("abort_rem",  M_div_rem,  last_r);
        check("abort_bz",   {31'd0, M_div_by_zero}, {31'd0, last_z});
        run_op(32'hFFFFFFFF, 32'h10, 1'b0, '{32'h0FFFFFFF, 32'hF, 1'b0, 0});

        // Abort together with start in IDLE: start is dropped.
        @(negedge clk);
        E_start = 1'b1; E_abort = 1'b1; E_src1 = 32'd50; E_src2 = 32'd5;
        @(negedge clk);
        E_start = 1'b0; E_abort = 1'b0;
        check("abort_start_busy", {31'd0, M_div_busy}, 32'd0);

        // Reset at CALC cycle 20: outputs cleared, no done, then normal restart.
        start_op(32'd500, 32'd7, 1'b0, 1'b0, e);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, M_div_busy},    32'd0);
        check("mid_rst_quot", M_div_quot,             32'd0);
        check("mid_rst_rem",  M_div_rem,              32'd0);
        check("mid_rst_bz",   {31'd0, M_div_by_zero}, 32'd0);
        repeat (LATENCY + 5) @(negedge clk);
        run_op(32'd100, 32'd7, 1'b0, '{32'd14, 32'd2, 1'b0, 0});

        // Starts while busy and in the DONE cycle are ignored.
        start_op(32'h12345678, 32'h1234, 1'b0, 1'b1, ref_div(32'h12345678, 32'h1234, 1'b0));
        repeat (4) @(negedge clk);
        E_start = 1'b1; E_src1 = 32'd1; E_src2 = 32'd1;
        @(negedge clk);
        E_start = 1'b0;
        begin
            int n = 0;
            while (!M_div_done && n < 2 * LATENCY) begin
                @(negedge clk);
                n++;
            end
            check("done_seen_before_timeout", {31'd0, M_div_done}, 32'd1);
        end
        E_start = 1'b1;
        @(negedge clk);
        E_start = 1'b0;
        check("done_cycle_start_ignored", {31'd0, M_div_busy}, 32'd0);
        repeat (LATENCY + 5) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        check("done_count", done_seen, accepted);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_cpu_cpu_div_cell.md
CPU_CPU_CPU_DIV_CELL -- requirements
Module: cpu_cpu_cpu_div_cell

Interface
REQ-001 The block SHALL have exactly one parameter: DATA_W, default 32, operand and result width; legal values are even integers of 8 or more.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have the following ports, with widths as listed:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- E_src1  in  DATA_W  dividend.
- E_src2  in  DATA_W  divisor.
- E_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- E_start  in  1  request a divide.
- E_abort  in  1  pipeline flush; kills any operation in flight.
- M_div_busy  out  1  operation in progress.
- M_div_done  out  1  one-cycle result-valid pulse.
- M_div_quot  out  DATA_W  quotient.
- M_div_rem  out  DATA_W  remainder.
- M_div_by_zero  out  1  divisor was zero for the reported result.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, CALC, FIX and DONE.
REQ-005 In IDLE, E_start=1 with E_abort=0 SHALL be accepted at that clock edge, and the accepting edge SHALL latch E_src1, E_src2 and E_signed.
REQ-006 Operands SHALL NOT be sampled again after acceptance; input changes during busy SHALL have no effect.
REQ-007 On acceptance the FSM SHALL enter CALC, which runs exactly DATA_W cycles.
- Each CALC cycle SHALL perform one radix-2 shift/subtract iteration on operand magnitudes.
- An internal iteration counter SHALL count 0..DATA_W-1 and then move the FSM to FIX.
REQ-008 FIX SHALL last one cycle and apply the sign correction:
- quotient negated when E_signed=1 and the operand signs differ;
- remainder negated when E_signed=1 and the dividend is negative.
REQ-009 DONE SHALL last one cycle and assert M_div_done=1, then the FSM SHALL return to IDLE.
REQ-010 M_div_done SHALL be high exactly DATA_W+2 clock edges after the accepting edge (34 edges for DATA_W=32).
REQ-011 M_div_busy SHALL be 1 in CALC, FIX and DONE, and 0 in IDLE.
REQ-012 E_start while busy SHALL be ignored, with no queueing.
REQ-013 E_start in the DONE cycle SHALL be ignored; a new operation is accepted no earlier than the first IDLE cycle.
REQ-014 Unsigned arithmetic SHALL satisfy quot = floor(src1/src2) and rem = src1 - quot*src2.
REQ-015 Signed arithmetic SHALL truncate toward zero and give the remainder the sign of the dividend, so |rem| < |src2|.
REQ-016 Signed overflow (most-negative / -1) SHALL give quot = most-negative and rem = 0, with no flag.
REQ-017 Divisor zero SHALL give quot = all-ones, rem = dividend unchanged, and M_div_by_zero=1.
- Latency SHALL be unchanged for divisor zero.
- M_div_by_zero SHALL be 0 for any nonzero divisor.
REQ-018 M_div_quot, M_div_rem and M_div_by_zero SHALL update only at the edge entering DONE and SHALL hold until the next DONE.
REQ-019 Intermediate CALC values SHALL NOT appear on the outputs.
REQ-020 E_abort=1 in CALC, FIX or DONE SHALL return the FSM to IDLE at that edge.
- M_div_busy SHALL read 0 in the next cycle.
- No M_div_done pulse SHALL occur for the aborted operation.
- The result outputs SHALL keep their prior values.
REQ-021 E_abort=1 and E_start=1 together in IDLE SHALL be resolved as abort: the start is not accepted.
REQ-022 The iteration SHALL use a DATA_W+1-bit partial remainder so the magnitude of the most-negative operand is handled without loss.

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, counter=0, M_div_busy=0, M_div_done=0, M_div_quot=0, M_div_rem=0 and M_div_by_zero=0.
REQ-024 reset SHALL take priority over E_start and E_abort.
REQ-025 reset asserted mid-operation SHALL cancel the operation with no M_div_done pulse.
REQ-026 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-027 The bench SHALL cover an unsigned divide: 100/7, E_signed=0 -> done at edge 34, quot=14, rem=2, by_zero=0, busy high for 34 cycles.
REQ-028 The bench SHALL cover signed divides:
- -7/2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1);
- 7/-2 -> quot=-3, rem=1.
REQ-029 The bench SHALL cover signed overflow: 0x80000000 / 0xFFFFFFFF, signed -> quot=0x80000000, rem=0, by_zero=0.
REQ-030 The bench SHALL cover divide by zero: 0x12345678/0 -> quot=0xFFFFFFFF, rem=0x12345678, by_zero=1, latency 34.
REQ-031 The bench SHALL cover abort and restart:
- E_abort at CALC cycle 10 -> no done, outputs hold the previous result;
- an immediate new start 0xFFFFFFFF/0x10 unsigned -> quot=0x0FFFFFFF, rem=0xF.
REQ-032 The bench SHALL cover reset and ignored starts:
- reset pulse at CALC cycle 20 -> all outputs 0 the next cycle, no done;
- E_start pulses while busy -> ignored, exactly one done per accepted start.
